breakout_renderer: RTL and testbench

- Pixel-generation and game-logic stage that sits directly upstream of the VGA timing driver.
- Consumes the driver's pixel coordinates (x, y) and videoOn, and produces the 8-bit RGB332 pixel (rgb) that feeds the driver's rgbin.
- Holds all Breakout game state: paddle, ball, a 4x10 brick wall, lives, score and game phase.
- Game state advances once per frame, during vertical blanking.

---
 rtl/breakout_renderer.sv | 204 ++++++++++++++++++++
 tb/tb_breakout_renderer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/breakout_renderer.sv
// Breakout game state and pixel generator feeding the VGA timing driver's rgbin.
// Game state steps once per frame at the (0,480) blanking tick; rgb lags (x,y) by one clk.
module breakout_renderer #(
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 440,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int BRICK_ROWS   = 4,
    parameter int BRICK_COLS   = 10,
    parameter int BRICK_H      = 16,
    parameter int BRICK_TOP    = 32,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       start,
    output logic [7:0] rgb,
    output logic [1:0] lives,
    output logic [5:0] score,
    output logic [1:0] phase
);
    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, WIN = 2'd2, OVER = 2'd3} phase_e;

    localparam int         NB       = BRICK_ROWS * BRICK_COLS;
    localparam int         IW       = $clog2(NB);
    localparam logic [9:0] PAD_W    = 10'(PADDLE_W);
    localparam logic [9:0] PAD_H    = 10'(PADDLE_H);
    localparam logic [9:0] PAD_Y    = 10'(PADDLE_Y);
    localparam logic [9:0] PAD_SPD  = 10'(PADDLE_SPEED);
    localparam logic [9:0] PAD_MAX  = 10'(640 - PADDLE_W);
    localparam logic [9:0] PAD_INIT = 10'((640 - PADDLE_W) / 2);
    localparam logic [9:0] BSZ      = 10'(BALL_SIZE);
    localparam logic [9:0] BHALF    = 10'(BALL_SIZE / 2);
    localparam logic [9:0] BSPD     = 10'(BALL_SPEED);
    localparam logic [9:0] SERVE_X  = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] SERVE_Y  = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] RWALL    = 10'(640 - BALL_SIZE - BALL_SPEED);
    localparam logic [9:0] FLOOR    = 10'(480 - BALL_SIZE);
    localparam logic [9:0] WALL_T   = 10'(BRICK_TOP);
    localparam logic [9:0] WALL_B   = 10'(BRICK_TOP + BRICK_ROWS * BRICK_H);
    localparam logic [1:0] LIVES_I  = 2'(LIVES);

    phase_e        phase_q;
    logic [1:0]    lives_q;
    logic [5:0]    score_q;
    logic [9:0]    paddle_x_q, paddle_x_d;
    logic [9:0]    ball_x_q, ball_y_q;
    logic          dx_pos_q, dy_down_q;
    logic [NB-1:0] bricks_q;
    logic [7:0]    rgb_q;
    logic          at_vb_q;

    // Bricks are 64 px wide, so the column is simply the top four bits of x.
    function automatic logic [IW-1:0] cell_of(input logic [3:0] col, input logic [9:0] rel_y);
        return IW'((32'(rel_y) / 32'(BRICK_H)) * 32'(BRICK_COLS) + 32'(col));
    endfunction

    function automatic logic in_wall(input logic [3:0] col, input logic [9:0] py);
        return (py >= WALL_T) && (py < WALL_B) && (32'(col) < 32'(BRICK_COLS));
    endfunction

    // The driver holds each pixel for two clks, so the tick needs an edge on (0,480).
    logic at_vb, tick;
    assign at_vb = (x == 10'd0) && (y == 10'd480);
    assign tick  = at_vb && !at_vb_q;

    // ---------------- render path ----------------
    logic [9:0]    pix_ry;
    logic [31:0]   pix_row;
    logic [IW-1:0] pix_cell;
    logic          in_ball, in_pad, in_brick;
    logic [7:0]    pix;

    always_comb begin
        pix_ry   = y - WALL_T;
        pix_row  = 32'(pix_ry) / 32'(BRICK_H);
        pix_cell = cell_of(x[9:6], pix_ry);
        in_ball  = (x >= ball_x_q) && (x < ball_x_q + BSZ) &&
                   (y >= ball_y_q) && (y < ball_y_q + BSZ);
        in_pad   = (x >= paddle_x_q) && (x < paddle_x_q + PAD_W) &&
                   (y >= PAD_Y) && (y < PAD_Y + PAD_H);
        in_brick = in_wall(x[9:6], y) && bricks_q[pix_cell] && (x[5:0] != 6'd63) &&
                   (32'(pix_ry) % 32'(BRICK_H) != 32'(BRICK_H - 1));
        pix = 8'h00;
        if (!video_on)   pix = 8'h00;
        else if (in_ball) pix = 8'hFC;
        else if (in_pad)  pix = 8'hFF;
        else if (in_brick) begin
            case (pix_row)
                32'd0:   pix = 8'hE0;
                32'd1:   pix = 8'hF0;
                32'd2:   pix = 8'h1C;
                default: pix = 8'h03;
            endcase
        end
    end

    // ---------------- per-frame physics ----------------
    always_comb begin
        paddle_x_d = paddle_x_q;
        if (btn_left && !btn_right)
            paddle_x_d = (paddle_x_q > PAD_SPD) ? paddle_x_q - PAD_SPD : 10'd0;
        else if (btn_right && !btn_left)
            paddle_x_d = (paddle_x_q + PAD_SPD > PAD_MAX) ? PAD_MAX : paddle_x_q + PAD_SPD;
    end

    logic [9:0]    cx, cy, bx_n, by_n;
    logic [IW-1:0] hit_cell;
    logic          brick_hit, hit_l, hit_r, hit_t, hit_pad, miss, dx_n, dy_n;
    logic [NB-1:0] bricks_n;

    always_comb begin
        cx        = ball_x_q + BHALF;
        cy        = ball_y_q + BHALF;
        hit_cell  = cell_of(cx[9:6], cy - WALL_T);
        brick_hit = in_wall(cx[9:6], cy) && bricks_q[hit_cell];
        bricks_n  = bricks_q;
        if (brick_hit) bricks_n[hit_cell] = 1'b0;
        hit_l   = !dx_pos_q && (ball_x_q <= BSPD);
        hit_r   = dx_pos_q && (ball_x_q >= RWALL);
        hit_t   = !dy_down_q && (ball_y_q <= BSPD);
        // Paddle has already moved this tick, so test against its new position.
        hit_pad = dy_down_q && (ball_y_q + BSZ >= PAD_Y) && (ball_y_q + BSZ <= PAD_Y + PAD_H) &&
                  (cx >= paddle_x_d) && (cx < paddle_x_d + PAD_W);
        miss    = dy_down_q && (ball_y_q >= FLOOR);
        dx_n    = hit_l ? 1'b1 : (hit_r ? 1'b0 : dx_pos_q);
        dy_n    = hit_t ? 1'b1 : (brick_hit ? ~dy_down_q : (hit_pad ? 1'b0 : dy_down_q));
        bx_n    = dx_n ? ball_x_q + BSPD : ball_x_q - BSPD;
        by_n    = dy_n ? ball_y_q + BSPD : ball_y_q - BSPD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q      <= 8'h00;
            at_vb_q    <= 1'b0;
            phase_q    <= SERVE;
            lives_q    <= LIVES_I;
            score_q    <= 6'd0;
            paddle_x_q <= PAD_INIT;
            ball_x_q   <= PAD_INIT + SERVE_X;
            ball_y_q   <= SERVE_Y;
            dx_pos_q   <= 1'b1;
            dy_down_q  <= 1'b0;
            bricks_q   <= '1;
        end else begin
            rgb_q   <= pix;
            at_vb_q <= at_vb;
            if (tick) begin
                paddle_x_q <= paddle_x_d;
                case (phase_q)
                    SERVE: begin
                        ball_x_q <= paddle_x_d + SERVE_X;
                        ball_y_q <= SERVE_Y;
                        if (start) begin
                            phase_q   <= PLAY;
                            dx_pos_q  <= 1'b1;
                            dy_down_q <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (miss) begin
                            lives_q <= lives_q - 2'd1;
                            phase_q <= (lives_q == 2'd1) ? OVER : SERVE;
                        end else begin
                            ball_x_q  <= bx_n;
                            ball_y_q  <= by_n;
                            dx_pos_q  <= dx_n;
                            dy_down_q <= dy_n;
                            bricks_q  <= bricks_n;
                            if (brick_hit) begin
                                score_q <= score_q + 6'd1;
                                if (bricks_n == '0) phase_q <= WIN;
                            end
                        end
                    end
                    default: begin
                        if (start) begin
                            phase_q   <= SERVE;
                            lives_q   <= LIVES_I;
                            score_q   <= 6'd0;
                            bricks_q  <= '1;
                            ball_x_q  <= paddle_x_d + SERVE_X;
                            ball_y_q  <= SERVE_Y;
                            dx_pos_q  <= 1'b1;
                            dy_down_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign rgb   = rgb_q;
    assign lives = lives_q;
    assign score = score_q;
    assign phase = phase_q;
endmodule

// File: tb/tb_breakout_renderer.sv
// Directed bench for breakout_renderer: render table at reset, then hand-traced
// paddle, serve, bounce, brick, miss, win, game-over and mid-frame reset sequences.
module tb_breakout_renderer;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       video_on, btn_left, btn_right, start;
    logic [7:0] rgb;
    logic [1:0] lives, phase;
    logic [5:0] score;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       vo;
        logic [7:0] exp_rgb;
    } pvec_t;

    pvec_t tbl [20];

    breakout_renderer dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on),
        .btn_left(btn_left), .btn_right(btn_right), .start(start),
        .rgb(rgb), .lives(lives), .score(score), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
        end
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic vo,
                       input logic [7:0] e, input string nm);
        @(negedge clk);
        x = px; y = py; video_on = vo;
        @(negedge clk);
        chk(nm, 40'(rgb), 40'(e));
    endtask

    // One frame boundary: (0,480) held two clks as the driver would, buttons valid across it.
    task automatic frame(input logic l, input logic r, input logic s);
        @(negedge clk);
        btn_left = l; btn_right = r; start = s; video_on = 1'b0; x = 10'd0; y = 10'd479;
        @(negedge clk);
        y = 10'd480;
        @(negedge clk);
        @(negedge clk);
        y = 10'd481; btn_left = 1'b0; btn_right = 1'b0; start = 1'b0;
    endtask

    task automatic frames(input int n, input logic l, input logic r, input logic s);
        for (int i = 0; i < n; i++) frame(l, r, s);
    endtask

    task automatic chk_ball(input string nm, input logic [9:0] bx, input logic [9:0] by);
        chk({nm, "_bx"}, 40'(dut.ball_x_q), 40'(bx));
        chk({nm, "_by"}, 40'(dut.ball_y_q), 40'(by));
    endtask

    initial begin
        tbl = '{
            '{10'd300, 10'd444, 1'b1, 8'hFF}, '{10'd320, 10'd436, 1'b1, 8'hFC},
            '{10'd320, 10'd436, 1'b0, 8'h00}, '{10'd0,   10'd32,  1'b1, 8'hE0},
            '{10'd63,  10'd32,  1'b1, 8'h00}, '{10'd64,  10'd47,  1'b1, 8'h00},
            '{10'd64,  10'd48,  1'b1, 8'hF0}, '{10'd100, 10'd64,  1'b1, 8'h1C},
            '{10'd638, 10'd94,  1'b1, 8'h03}, '{10'd639, 10'd94,  1'b1, 8'h00},
            '{10'd200, 10'd96,  1'b1, 8'h00}, '{10'd200, 10'd31,  1'b1, 8'h00},
            '{10'd287, 10'd444, 1'b1, 8'h00}, '{10'd351, 10'd447, 1'b1, 8'hFF},
            '{10'd352, 10'd444, 1'b1, 8'h00}, '{10'd300, 10'd448, 1'b1, 8'h00},
            '{10'd315, 10'd432, 1'b1, 8'h00}, '{10'd323, 10'd439, 1'b1, 8'hFC},
            '{10'd320, 10'd440, 1'b1, 8'hFF}, '{10'd324, 10'd435, 1'b1, 8'h00}
        };

        rst = 1'b1; x = 10'd320; y = 10'd436; video_on = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 40'(rgb), 40'h00);
        chk("rst_lives", 40'(lives), 40'd3);
        chk("rst_score", 40'(score), 40'd0);
        chk("rst_phase", 40'(phase), 40'd0);
        chk("rst_paddle", 40'(dut.paddle_x_q), 40'd288);
        chk_ball("rst", 10'd316, 10'd432);
        chk("rst_bricks", 40'(dut.bricks_q), 40'hFF_FFFF_FFFF);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            pix(tbl[i].px, tbl[i].py, tbl[i].vo, tbl[i].exp_rgb, $sformatf("render%0d", i));

        // Paddle left, clamp, mid-frame inputs, both buttons, right clamp
        frame(1'b1, 1'b0, 1'b0);
        chk("pad_l1", 40'(dut.paddle_x_q), 40'd284);
        chk("serve_track1", 40'(dut.ball_x_q), 40'd312);
        frames(71, 1'b1, 1'b0, 1'b0);
        chk("pad_l72", 40'(dut.paddle_x_q), 40'd0);
        frames(8, 1'b1, 1'b0, 1'b0);
        chk("pad_l80", 40'(dut.paddle_x_q), 40'd0);
        chk_ball("serve_track0", 10'd28, 10'd432);
        @(negedge clk);
        btn_right = 1'b1; start = 1'b1; x = 10'd100; y = 10'd200;
        repeat (10) @(negedge clk);
        btn_right = 1'b0; start = 1'b0;
        chk("midframe_pad", 40'(dut.paddle_x_q), 40'd0);
        chk("midframe_phase", 40'(phase), 40'd0);
        frames(10, 1'b1, 1'b1, 1'b0);
        chk("pad_both", 40'(dut.paddle_x_q), 40'd0);
        frames(150, 1'b0, 1'b1, 1'b0);
        chk("pad_rclamp", 40'(dut.paddle_x_q), 40'd576);
        chk_ball("serve_right", 10'd604, 10'd432);
        pix(10'd576, 10'd440, 1'b1, 8'hFF, "pad_edge_in");
        pix(10'd575, 10'd440, 1'b1, 8'h00, "pad_edge_out");

        // Serve, right-wall bounce, brick row3 col4
        frame(1'b0, 1'b0, 1'b1);
        chk("serve_phase", 40'(phase), 40'd1);
        frame(1'b0, 1'b0, 1'b0);
        chk_ball("play1", 10'd606, 10'd430);
        frames(12, 1'b0, 1'b0, 1'b0);
        chk_ball("pre_rwall", 10'd630, 10'd406);
        frame(1'b0, 1'b0, 1'b0);
        chk_ball("rwall", 10'd628, 10'd404);
        chk("rwall_dx", 40'(dut.dx_pos_q), 40'd0);
        frames(157, 1'b0, 1'b0, 1'b0);
        chk_ball("pre_brick", 10'd314, 10'd90);
        chk("pre_brick_score", 40'(score), 40'd0);
        pix(10'd260, 10'd85, 1'b1, 8'h03, "brick34_on");
        pix(10'd316, 10'd92, 1'b1, 8'hFC, "ball_over_brick");
        frame(1'b0, 1'b0, 1'b0);
        chk("brick_score", 40'(score), 40'd1);
        chk("brick_bit34", 40'(dut.bricks_q), 40'hFB_FFFF_FFFF);
        chk_ball("brick", 10'd312, 10'd92);
        chk("brick_dy", 40'(dut.dy_down_q), 40'd1);
        pix(10'd260, 10'd85, 1'b1, 8'h00, "brick34_off");
        pix(10'd250, 10'd85, 1'b1, 8'h03, "brick33_on");

        // Left wall, then a miss back to SERVE
        frames(155, 1'b0, 1'b0, 1'b0);
        chk_ball("pre_lwall", 10'd2, 10'd402);
        frame(1'b0, 1'b0, 1'b0);
        chk_ball("lwall", 10'd4, 10'd404);
        frames(34, 1'b0, 1'b0, 1'b0);
        chk_ball("pre_miss", 10'd72, 10'd472);
        frame(1'b0, 1'b0, 1'b0);
        chk("miss_lives", 40'(lives), 40'd2);
        chk("miss_phase", 40'(phase), 40'd0);
        chk_ball("miss_nomove", 10'd72, 10'd472);

        // Last brick standing -> WIN in the hit tick, then frozen until start
        @(negedge clk);
        force dut.bricks_q = 40'h04_0000_0000;
        @(negedge clk);
        release dut.bricks_q;
        frame(1'b0, 1'b0, 1'b1);
        frames(172, 1'b0, 1'b0, 1'b0);
        chk("win_score", 40'(score), 40'd2);
        chk("win_phase", 40'(phase), 40'd2);
        chk("win_bricks", 40'(dut.bricks_q), 40'h0);
        chk_ball("win", 10'd312, 10'd92);
        frames(3, 1'b0, 1'b0, 1'b0);
        chk("win_hold_phase", 40'(phase), 40'd2);
        chk_ball("win_frozen", 10'd312, 10'd92);
        pix(10'd0, 10'd32, 1'b1, 8'h00, "win_no_bricks");
        frame(1'b0, 1'b0, 1'b1);
        chk("win_restart_phase", 40'(phase), 40'd0);
        chk("win_restart_lives", 40'(lives), 40'd3);
        chk("win_restart_score", 40'(score), 40'd0);
        pix(10'd260, 10'd85, 1'b1, 8'h03, "win_restart_brick");

        // Miss on the last life -> OVER, start restarts
        @(negedge clk);
        force dut.lives_q = 2'd1;
        @(negedge clk);
        release dut.lives_q;
        frame(1'b0, 1'b0, 1'b1);
        frames(172, 1'b0, 1'b0, 1'b0);
        chk("over_run_score", 40'(score), 40'd1);
        frames(191, 1'b0, 1'b0, 1'b0);
        chk("over_lives", 40'(lives), 40'd0);
        chk("over_phase", 40'(phase), 40'd3);
        frame(1'b0, 1'b0, 1'b0);
        chk("over_hold", 40'(phase), 40'd3);
        frame(1'b0, 1'b0, 1'b1);
        chk("over_restart_phase", 40'(phase), 40'd0);
        chk("over_restart_lives", 40'(lives), 40'd3);
        chk("over_restart_score", 40'(score), 40'd0);
        chk("over_restart_bricks", 40'(dut.bricks_q), 40'hFF_FFFF_FFFF);
        pix(10'd0, 10'd32, 1'b1, 8'hE0, "over_restart_brick");

        // Reset mid-frame, then the first tick after release
        frames(5, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_pad", 40'(dut.paddle_x_q), 40'd556);
        @(negedge clk);
        x = 10'd320; y = 10'd436; video_on = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("midrst_rgb", 40'(rgb), 40'h00);
        chk("midrst_pad", 40'(dut.paddle_x_q), 40'd288);
        rst = 1'b0;
        frame(1'b0, 1'b1, 1'b0);
        chk("post_rst_pad", 40'(dut.paddle_x_q), 40'd292);
        chk_ball("post_rst", 10'd320, 10'd432);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
